// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions: memory op encoding, register names, LSU FSM state
// and small decode helpers.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    ld_byte_s, ld_byte_u, ld_half_word_s, ld_half_word_u, ld_word,
    str_byte, str_half_word, str_word
  } mem_operation_t;

  typedef logic [4:0] regName_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Loads occupy the low encodings, so a single compare classifies the op.
  function automatic logic is_load(mem_operation_t op);
    return op <= ld_word;
  endfunction

  function automatic logic [1:0] op_size(mem_operation_t op);
    case (op)
      ld_byte_s, ld_byte_u, str_byte:                 return SZ_BYTE;
      ld_half_word_s, ld_half_word_u, str_half_word:  return SZ_HALF;
      default:                                        return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extractor: picks the byte/half out of a read word by offset and
// sign- or zero-extends it according to the load op.
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  mem_operation_t  mem_op,
  output logic [XLEN-1:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (mem_op)
      ld_byte_s:      result = {{(XLEN-8){b[7]}}, b};
      ld_byte_u:      result = {{(XLEN-8){1'b0}}, b};
      ld_half_word_s: result = {{(XLEN-16){h[15]}}, h};
      ld_half_word_u: result = {{(XLEN-16){1'b0}}, h};
      default:        result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding req/gnt/rvalid data-memory master with byte lanes,
// load extension and wait timeout. Optional MISALIGN_TRAP_EN traps misaligned halves/words.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  mem_operation_t  mem_op,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  input  regName_t        lsu_rd,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output regName_t        rd_out,
  output logic            bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  localparam int NUM_LANES = XLEN / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t     state;
  mem_operation_t op_q;
  logic [1:0]     off_q;
  regName_t       rd_q;
  logic [CW-1:0]  cnt;

  logic [1:0]                 sz;
  logic [1:0]                 off;
  logic [NUM_LANES-1:0]       be_nxt;
  logic [NUM_LANES-1:0][7:0]  wdata_nxt;
  logic [XLEN-1:0]            load_res;
  logic                       timeout_hit;

  assign sz = op_size(mem_op);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Without the trap, low address bits are dropped so the access is naturally aligned.
`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((sz == SZ_HALF) && lsu_addr[0]) ||
                      ((sz == SZ_WORD) && (lsu_addr[1:0] != 2'b00));
  assign off = lsu_addr[1:0];
`else
  assign off = (sz == SZ_BYTE) ? lsu_addr[1:0] :
               (sz == SZ_HALF) ? {lsu_addr[1], 1'b0} : 2'b00;
`endif

  always_comb begin
    case (sz)
      SZ_BYTE: be_nxt = NUM_LANES'(1) << off;
      SZ_HALF: be_nxt = NUM_LANES'(3) << off;
      default: be_nxt = '1;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdata_nxt[i] = (sz == SZ_BYTE) ? lsu_wdata[7:0] :
                          (sz == SZ_HALF) ? lsu_wdata[8*(i%2) +: 8] :
                                            lsu_wdata[8*i +: 8];
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .word   (dmem_rdata),
    .offset (off_q),
    .mem_op (op_q),
    .result (load_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= ld_byte_s;
      off_q      <= '0;
      rd_q       <= '0;
      cnt        <= '0;
      lsu_ready  <= 1'b1;
      done       <= 1'b0;
      bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign   <= 1'b0;
`endif
      rdata      <= '0;
      rd_out     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: if (lsu_valid) begin
          op_q      <= mem_op;
          off_q     <= off;
          rd_q      <= lsu_rd;
          lsu_ready <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            state    <= DONE;
            done     <= 1'b1;
            misalign <= 1'b1;
            rdata    <= '0;
            rd_out   <= '0;
          end else
`endif
          begin
            state      <= REQ;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= !is_load(mem_op);
            dmem_be    <= be_nxt;
            dmem_addr  <= {lsu_addr[XLEN-1:2], 2'b00};
            dmem_wdata <= wdata_nxt;
          end
        end
        REQ: begin
          // rvalid arriving alongside gnt is a protocol error and is not looked at here.
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= '0;
            cnt      <= '0;
            if (is_load(op_q)) begin
              state <= WAIT;
            end else begin
              state  <= DONE;
              done   <= 1'b1;
              rd_out <= '0;
            end
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= '0;
            state    <= DONE;
            done     <= 1'b1;
            bus_err  <= 1'b1;
            rdata    <= '0;
            rd_out   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state  <= DONE;
            done   <= 1'b1;
            rdata  <= load_res;
            rd_out <= rd_q;
          end else if (timeout_hit) begin
            state   <= DONE;
            done    <= 1'b1;
            bus_err <= 1'b1;
            rdata   <= '0;
            rd_out  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          lsu_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, timeout, alignment handling and
// mid-access reset, checked with immediate assertions against hand-computed values.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           lsu_valid;
  logic           lsu_ready;
  mem_operation_t mem_op;
  logic [31:0]    lsu_addr, lsu_wdata;
  regName_t       lsu_rd;
  logic           done;
  logic [31:0]    rdata;
  regName_t       rd_out;
  logic           bus_err;
`ifdef MISALIGN_TRAP_EN
  logic           misalign;
`endif
  logic           dmem_req, dmem_we;
  logic [3:0]     dmem_be;
  logic [31:0]    dmem_addr, dmem_wdata;
  logic           dmem_gnt, dmem_rvalid;
  logic [31:0]    dmem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .mem_op(mem_op),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rd(lsu_rd),
    .done(done), .rdata(rdata), .rd_out(rd_out), .bus_err(bus_err),
`ifdef MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
  endtask

  // Load with gnt in the first REQ cycle (junk rvalid alongside it) and rvalid next cycle.
  task automatic do_load(input string tag, input mem_operation_t op, input logic [31:0] addr,
                         input regName_t rd, input logic [31:0] word,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    lsu_valid = 1'b1; mem_op = op; lsu_addr = addr; lsu_rd = rd;
    tick();
    lsu_valid = 1'b0;
    chk({tag, ".req"}, dmem_req, 1);
    chk({tag, ".we"}, dmem_we, 0);
    chk({tag, ".addr"}, dmem_addr, exp_addr);
    chk({tag, ".be"}, dmem_be, exp_be);
    chk({tag, ".ready"}, lsu_ready, 0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_DEAD;
    tick();
    dmem_gnt = 1'b0;
    chk({tag, ".req_drop"}, dmem_req, 0);
    chk({tag, ".no_early_done"}, done, 0);
    dmem_rdata = word;
    tick();
    dmem_rvalid = 1'b0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".rdata"}, rdata, exp_data);
    chk({tag, ".rd_out"}, rd_out, 32'(rd));
    chk({tag, ".be_idle"}, dmem_be, 0);
    chk({tag, ".addr_hold"}, dmem_addr, exp_addr);
    tick();
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".ready_back"}, lsu_ready, 1);
  endtask

  task automatic do_store(input string tag, input mem_operation_t op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] keep_rdata);
    lsu_valid = 1'b1; mem_op = op; lsu_addr = addr; lsu_wdata = wd; lsu_rd = 5'd9;
    tick();
    lsu_valid = 1'b0;
    chk({tag, ".req"}, dmem_req, 1);
    chk({tag, ".we"}, dmem_we, 1);
    chk({tag, ".addr"}, dmem_addr, exp_addr);
    chk({tag, ".be"}, dmem_be, exp_be);
    chk({tag, ".wdata"}, dmem_wdata, exp_wd);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".rd_out"}, rd_out, 0);
    chk({tag, ".rdata_kept"}, rdata, keep_rdata);
    chk({tag, ".req_drop"}, dmem_req, 0);
    tick();
    chk({tag, ".ready_back"}, lsu_ready, 1);
  endtask

  initial begin
    rst = 1'b1; lsu_valid = 1'b0; mem_op = ld_byte_s; lsu_addr = '0; lsu_wdata = '0;
    lsu_rd = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick();
    tick();
    chk("rst.ready", lsu_ready, 1);
    chk("rst.done", done, 0);
    chk("rst.req", dmem_req, 0);
    chk("rst.be", dmem_be, 0);
    chk("rst.addr", dmem_addr, 0);
    chk("rst.wdata", dmem_wdata, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.bus_err", bus_err, 0);
    rst = 1'b0;
    tick();

    do_load("lb_s", ld_byte_s, 32'h103, 5'd5, 32'h8012_3456, 32'h100, 4'b1000, 32'hFFFF_FF80);
    do_load("lh_u", ld_half_word_u, 32'h202, 5'd6, 32'hBEEF_1234, 32'h200, 4'b1100, 32'h0000_BEEF);
    do_load("lh_s", ld_half_word_s, 32'h202, 5'd7, 32'hBEEF_1234, 32'h200, 4'b1100, 32'hFFFF_BEEF);
    do_load("lb_u", ld_byte_u, 32'h101, 5'd8, 32'h0000_80FF, 32'h100, 4'b0010, 32'h0000_0080);
    do_load("lw", ld_word, 32'h300, 5'd31, 32'hCAFE_F00D, 32'h300, 4'b1111, 32'hCAFE_F00D);

    do_store("sb", str_byte, 32'h11, 32'h0000_00A5, 32'h10, 4'b0010, 32'hA5A5_A5A5, 32'hCAFE_F00D);
    do_store("sh", str_half_word, 32'h22, 32'h1234_CAFE, 32'h20, 4'b1100, 32'hCAFE_CAFE, 32'hCAFE_F00D);
    do_store("sw", str_word, 32'h40, 32'h1122_3344, 32'h40, 4'b1111, 32'h1122_3344, 32'hCAFE_F00D);

    // No grant ever: four waiting cycles, then bus error.
    lsu_valid = 1'b1; mem_op = ld_word; lsu_addr = 32'h50; lsu_rd = 5'd7;
    tick();
    lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to.req_held", dmem_req, 1);
      chk("to.not_done", done, 0);
    end
    tick();
    chk("to.done", done, 1);
    chk("to.bus_err", bus_err, 1);
    chk("to.req_drop", dmem_req, 0);
    chk("to.rdata", rdata, 0);
    chk("to.rd_out", rd_out, 0);
    tick();
    chk("to.err_pulse", bus_err, 0);
    chk("to.ready", lsu_ready, 1);
    do_load("after_to", ld_byte_u, 32'h60, 5'd2, 32'h0000_0042, 32'h60, 4'b0001, 32'h0000_0042);

`ifdef MISALIGN_TRAP_EN
    lsu_valid = 1'b1; mem_op = ld_word; lsu_addr = 32'h6; lsu_rd = 5'd3;
    tick();
    lsu_valid = 1'b0;
    chk("mis.done", done, 1);
    chk("mis.flag", misalign, 1);
    chk("mis.req", dmem_req, 0);
    chk("mis.rd_out", rd_out, 0);
    chk("mis.rdata", rdata, 0);
    tick();
    chk("mis.pulse", misalign, 0);
    chk("mis.ready", lsu_ready, 1);
`else
    do_load("lw_mis", ld_word, 32'h6, 5'd3, 32'h0BAD_F00D, 32'h4, 4'b1111, 32'h0BAD_F00D);
`endif

    // Reset while waiting for read data; the late rvalid must not complete anything.
    lsu_valid = 1'b1; mem_op = ld_word; lsu_addr = 32'h80; lsu_rd = 5'd4;
    tick();
    lsu_valid = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rw.in_wait", dmem_req, 0);
    rst = 1'b1;
    #1;
    chk("rw.ready", lsu_ready, 1);
    chk("rw.addr", dmem_addr, 0);
    chk("rw.rdata", rdata, 0);
    chk("rw.done", done, 0);
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    chk("rw.late_done", done, 0);
    chk("rw.late_rdata", rdata, 0);
    chk("rw.late_rd", rd_out, 0);
    chk("rw.ready_after", lsu_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
